// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Pure declarations; no logic, no latency.
// No flow control of its own; used by cla_seq_adder and its slice.
package cla_pkg;

    // Width of one carry-lookahead slice, in bits
    localparam int NIBBLE_W = 4;

    // Operation sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cla_state_t;

endpackage : cla_pkg

// File: rtl/cla_4_bit_adder.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
// Purely combinational, zero cycles.
// No handshake; the caller owns all sequencing.
module cla_4_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       p,
    output logic       g
);

    logic [3:0] pi;
    logic [3:0] gi;
    logic [4:0] c;

    // Bit propagate/generate, flattened lookahead carries, and group terms
    always_comb begin
        pi   = a ^ b;
        gi   = a & b;
        c[0] = cin;
        c[1] = gi[0] | (pi[0] & cin);
        c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
             | (pi[2] & pi[1] & pi[0] & cin);
        c[4] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0])
             | (pi[3] & pi[2] & pi[1] & pi[0] & cin);
        sum  = pi ^ c[3:0];
        cout = c[4];
        p    = &pi;
        g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    end

endmodule : cla_4_bit_adder

// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit adder behind a valid/ready request/response handshake.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge; one op per WIDTH/4+2 cycles.
// Backpressure: result holds in DONE until out_ready; in_ready is low outside IDLE.
// Optional: define SIGNED_OVF_EN to build the signed-overflow flag on out_ovf.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    cla_state_t          state;
    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [WIDTH-1:0]    psum;
    logic [WIDTH-1:0]    psum_next;
    logic                carry;
    logic [IDX_W-1:0]    idx;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                slice_p;
    logic                slice_g;

    // The low nibble of the shifting operand registers always holds the nibble being added
    cla_4_bit_adder u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .p    (slice_p),
        .g    (slice_g)
    );

    // Partial sum with the current slice result merged in at nibble position idx
    always_comb begin
        psum_next = psum;
        psum_next[NIBBLE_W*int'(idx) +: NIBBLE_W] = slice_sum;
    end

    // Sequencer: accept, iterate N slices, then hold the registered result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            psum      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
`ifdef SIGNED_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= in_a;
                        b_sh     <= in_b;
                        carry    <= in_cin;
                        idx      <= '0;
                        psum     <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    psum  <= psum_next;
                    carry <= slice_cout;
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Only now does the visible result change
                        out_sum   <= psum_next;
                        out_cout  <= slice_cout;
`ifdef SIGNED_OVF_EN
                        // Operand sign bits are in the low nibble of the shifted registers by now
                        out_ovf   <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1])
                                  && (slice_sum[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef SIGNED_OVF_EN
    assign out_ovf = 1'b0;
`endif

endmodule : cla_seq_adder
